mux2_arbiter: RTL and testbench

- Shares one 2:1 datapath mux between two packet-streaming requesters using valid/ready/last handshakes.
- Registers the mux select and holds it for a whole packet, from grant until the beat with last.
- Grants round-robin, so neither requester can starve the other.
- Sits in front of the output stage; the sel output is also exported so an external mux2 can be driven from it.

---
 rtl/mux2_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux2_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter that shares one 2:1 datapath mux
// between two packet-streaming requesters (valid/ready/last).
// The select is registered and held from grant until the beat with last.
// Data/last/valid pass combinationally through the registered select;
// only control is sequential.
// Optional feature: define MUX2_ARB_TIMEOUT_EN to add a watchdog that
// releases a grant whose owner has stayed idle for TIMEOUT_CYC cycles.
module mux2_arbiter #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy,
  output logic              timeout
);

  // The watchdog compares against TIMEOUT_CYC-1, which needs at least 2.
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout_cyc
    $error("mux2_arbiter: TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_d;
  logic   sel_d;
  logic   rr_ptr, rr_d;

  logic   grant;        // a packet grant is currently held
  logic   cur_valid;    // valid of the granted requester
  logic   cur_last;     // last of the granted requester
  logic   oth_valid;    // valid of the requester not granted
  logic   xfer;         // beat accepted this cycle
  logic   release_now;  // end of packet or watchdog expiry
  logic   winner;       // requester chosen when leaving IDLE
  logic   timeout_hit;  // watchdog expires this cycle

  assign grant     = (state != IDLE);
  assign cur_valid = sel ? req1_valid : req0_valid;
  assign cur_last  = sel ? req1_last  : req0_last;
  assign oth_valid = sel ? req0_valid : req1_valid;
  assign xfer      = grant & cur_valid & out_ready;

  // Datapath is a plain mux on the registered select.
  assign out_valid  = grant & cur_valid;
  assign out_data   = sel ? req1_data : req0_data;
  assign out_last   = cur_last;
  assign req0_ready = grant & ~sel & out_ready;
  assign req1_ready = grant &  sel & out_ready;
  assign busy       = grant;
  assign timeout    = timeout_hit;

  assign release_now = (xfer & cur_last) | timeout_hit;
  assign winner      = (req0_valid & req1_valid) ? rr_ptr : req1_valid;

  // Next-state selection: initial arbitration from IDLE, and re-arbitration
  // at end of packet (or watchdog) preferring the other requester.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state;
    sel_d   = sel;
    rr_d    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (req0_valid | req1_valid) begin
          sel_d   = winner;
          state_d = winner ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        if (release_now) begin
          rr_d = ~sel;
          if (oth_valid) begin
            sel_d   = ~sel;
            state_d = sel ? GNT0 : GNT1;
          end else if (!xfer) begin
            // Only the watchdog gets here: the owner counts as not valid.
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset drops any grant at once, mid-packet or not.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state  <= IDLE;
      sel    <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_d;
      sel    <= sel_d;
      rr_ptr <= rr_d;
    end
  end

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] idle_cnt;

  // Fires on the cycle the count would reach TIMEOUT_CYC.
  assign timeout_hit = grant & ~cur_valid &
                       (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count granted cycles with the owner idle; any progress restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (!grant || xfer || (state_d != state) || timeout_hit) begin
      idle_cnt <= '0;
    end else if (!cur_valid) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter: directed scenarios followed by a
// randomized phase, all checked cycle by cycle against a packet-level
// reference model (owner / priority / idle count as plain variables).
module tb_mux2_arbiter;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 4;
`ifdef MUX2_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              vld [2];
  logic              lst [2];
  logic [DATA_W-1:0] dat [2];
  logic              out_ready;
  logic              req0_ready, req1_ready;
  logic              out_valid, out_last, sel, busy, timeout;
  logic [DATA_W-1:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit m_idle;
  bit m_own;
  bit m_prio;
  int m_cnt;

  always #5 clk = ~clk;

  mux2_arbiter #(.DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(vld[0]),
    .req0_data (dat[0]),
    .req0_last (lst[0]),
    .req0_ready(req0_ready),
    .req1_valid(vld[1]),
    .req1_data (dat[1]),
    .req1_last (lst[1]),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit n, o, fire, to, moved;
    if (rst) begin
      m_idle = 1'b1; m_own = 1'b0; m_prio = 1'b0; m_cnt = 0;
      return;
    end
    if (m_idle) begin
      if (vld[0] || vld[1]) begin
        m_own  = (vld[0] && vld[1]) ? m_prio : vld[1];
        m_idle = 1'b0;
      end
      m_cnt = 0;
    end else begin
      n     = m_own;
      o     = ~m_own;
      fire  = vld[n] && out_ready;
      to    = TO_EN && !vld[n] && (m_cnt == TIMEOUT_CYC - 1);
      moved = 1'b0;
      if ((fire && lst[n]) || to) begin
        m_prio = o;
        if (vld[o]) begin
          m_own = o; moved = 1'b1;
        end else if (!fire) begin
          m_idle = 1'b1; moved = 1'b1;
        end
      end
      if (fire || moved) m_cnt = 0;
      else if (!vld[n])  m_cnt++;
    end
  endtask

  // Called just after a rising edge with inputs applied: check outputs
  // against the model, advance the model, and move to the next cycle.
  task automatic cycle();
    bit e_ov;
    #2;
    e_ov = !m_idle && vld[m_own];
    check("busy", busy, !m_idle);
    check("sel", sel, m_idle ? sel : m_own);
    check("out_valid", out_valid, e_ov);
    check("req0_ready", req0_ready, !m_idle && !m_own && out_ready);
    check("req1_ready", req1_ready, !m_idle &&  m_own && out_ready);
    check("timeout", timeout,
          TO_EN && !m_idle && !vld[m_own] && (m_cnt == TIMEOUT_CYC - 1));
    if (e_ov) begin
      check("out_data", out_data, dat[m_own]);
      check("out_last", out_last, lst[m_own]);
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; lst[k] = 1'b0; dat[k] = '0;
    end
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int bc [2];
    int pk [2];
    int lasts;
    int budget;
    bit fire [2];
    bit exp_order [4];

    exp_order[0] = 1'b0; exp_order[1] = 1'b1;
    exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    // Bring-up: reset held with req0 requesting.
    rst = 1'b1;
    clear_inputs();
    vld[0] = 1'b1;
    dat[0] = 8'h11;
    @(posedge clk);
    #1;
    m_idle = 1'b1; m_own = 1'b0; m_prio = 1'b0; m_cnt = 0;
    #1;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_busy", busy, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("a_busy", busy, 1'b1);
    check("a_sel", sel, 1'b0);
    check("a_ready_hi", req0_ready, 1'b1);
    out_ready = 1'b0;
    #1;
    check("a_ready_lo", req0_ready, 1'b0);
    cycle();

    // Single requester 1 sends A1,A2,A3.
    do_reset();
    vld[1] = 1'b1; dat[1] = 8'hA1; lst[1] = 1'b0;
    cycle();
    #1;
    check("b_sel1", sel, 1'b1);
    check("b_d1", out_data, 8'hA1);
    cycle();
    dat[1] = 8'hA2;
    #1;
    check("b_sel2", sel, 1'b1);
    check("b_d2", out_data, 8'hA2);
    cycle();
    dat[1] = 8'hA3; lst[1] = 1'b1;
    #1;
    check("b_sel3", sel, 1'b1);
    check("b_d3", out_data, 8'hA3);
    check("b_last", out_last, 1'b1);
    cycle();
    vld[1] = 1'b0; lst[1] = 1'b0;
    cycle();

    // Both requesters stream 2-beat packets back to back.
    do_reset();
    bc[0] = 0; bc[1] = 0; pk[0] = 0; pk[1] = 0;
    lasts = 0;
    budget = 0;
    while (lasts < 4 && budget < 40) begin
      for (int k = 0; k < 2; k++) begin
        vld[k] = 1'b1;
        dat[k] = 8'(k * 64 + pk[k] * 4 + bc[k]);
        lst[k] = (bc[k] == 1);
      end
      for (int k = 0; k < 2; k++)
        fire[k] = !m_idle && (m_own == 1'(k)) && out_ready;
      #1;
      if (fire[0] || fire[1]) begin
        if (!sel) check("c_req1_ready_while_sel0", req1_ready, 1'b0);
        if (lst[m_own]) begin
          check("c_grant_order", sel, exp_order[lasts]);
          lasts++;
        end
      end else if (budget > 0) begin
        check("c_no_bubble", out_valid, 1'b1);
      end
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (fire[k]) begin
          if (bc[k] == 1) begin bc[k] = 0; pk[k]++; end
          else bc[k]++;
        end
      end
      budget++;
    end
    check("c_packets_done", lasts, 4);

    // req0 mid-packet with req1 waiting; out_ready toggles.
    do_reset();
    vld[0] = 1'b1; dat[0] = 8'hC0; lst[0] = 1'b0;
    cycle();
    vld[1] = 1'b1; dat[1] = 8'hD0;
    cycle();
    dat[0] = 8'hC1; out_ready = 1'b0;
    #1;
    check("d_stall_r0", req0_ready, 1'b0);
    check("d_stall_r1", req1_ready, 1'b0);
    cycle();
    out_ready = 1'b1;
    #1;
    check("d_go_r0", req0_ready, 1'b1);
    check("d_go_data", out_data, 8'hC1);
    cycle();
    dat[0] = 8'hC2; lst[0] = 1'b1;
    #1;
    check("d_hold_sel", sel, 1'b0);
    cycle();
    vld[0] = 1'b0; lst[0] = 1'b0;
    #1;
    check("d_handoff_sel", sel, 1'b1);
    check("d_handoff_r1", req1_ready, 1'b1);
    check("d_handoff_data", out_data, 8'hD0);
    cycle();

    // Reset during beat 2 of a 4-beat req1 packet.
    do_reset();
    vld[1] = 1'b1; dat[1] = 8'hB0; lst[1] = 1'b0;
    cycle();
    cycle();
    dat[1] = 8'hB1;
    cycle();
    dat[1] = 8'hB2;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    vld[1] = 1'b0; vld[0] = 1'b1; dat[0] = 8'h5A;
    #1;
    check("e_busy", busy, 1'b0);
    check("e_sel", sel, 1'b0);
    check("e_out_valid", out_valid, 1'b0);
    check("e_r1", req1_ready, 1'b0);
    cycle();
    check("e_regrant_busy", busy, 1'b1);
    check("e_regrant_sel", sel, 1'b0);
    cycle();

    // Owner goes idle mid-packet while req1 waits (watchdog scenario).
    do_reset();
    vld[0] = 1'b1; vld[1] = 1'b1; dat[0] = 8'hE0; dat[1] = 8'hF0;
    cycle();
    cycle();
    vld[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("f_timeout", timeout, TO_EN && (i == 3));
      cycle();
    end
    #1;
    check("f_sel_after", sel, TO_EN);
    check("f_busy_after", busy, 1'b1);
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        vld[k] = ($urandom_range(0, 3) != 0);
        lst[k] = ($urandom_range(0, 2) == 0);
        dat[k] = DATA_W'($urandom);
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
